// File: rtl/ggt_pkg.sv
// Shared types and constants for the Euclidean GCD controller.
package ggt_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned ITER_W        = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START_MOD,
    WAIT_MOD,
    DONE
  } ggt_state_e;

  // Saturating increment for the iteration counter.
  function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ggt_euklid.sv
// Euclidean GCD controller that drives an external modulo unit through the mod_* handshake.
// Defining GGT_ITER_COUNT_EN adds iter_o, the number of modulo calls of the current computation.
module ggt_euklid
  import ggt_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WIDTH-1:0]  Zahl1_i,
  input  logic [WIDTH-1:0]  Zahl2_i,
  output logic              mod_start_o,
  output logic [WIDTH-1:0]  mod_zahl1_o,
  output logic [WIDTH-1:0]  mod_zahl2_o,
  input  logic              mod_valid_i,
  input  logic [WIDTH-1:0]  mod_ergebnis_i,
  output logic              busy_o,
  output logic              valid_o,
`ifdef GGT_ITER_COUNT_EN
  output logic [ITER_W-1:0] iter_o,
`endif
  output logic [WIDTH-1:0]  ergebnis_o
);

  ggt_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mod_start_o <= 1'b0;
      mod_zahl1_o <= '0;
      mod_zahl2_o <= '0;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
      ergebnis_o  <= '0;
`ifdef GGT_ITER_COUNT_EN
      iter_o      <= '0;
`endif
    end else begin
      mod_start_o <= 1'b0;
      valid_o     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q     <= Zahl1_i;
            b_q     <= Zahl2_i;
            busy_o  <= 1'b1;
            state_q <= LOAD;
`ifdef GGT_ITER_COUNT_EN
            iter_o  <= '0;
`endif
          end
        end
        LOAD: begin
          if (b_q == '0) begin
            ergebnis_o <= a_q;
            busy_o     <= 1'b0;
            valid_o    <= 1'b1;
            state_q    <= DONE;
          end else begin
            mod_start_o <= 1'b1;
            mod_zahl1_o <= a_q;
            mod_zahl2_o <= b_q;
            state_q     <= START_MOD;
`ifdef GGT_ITER_COUNT_EN
            iter_o      <= sat_inc(iter_o);
`endif
          end
        end
        START_MOD: state_q <= WAIT_MOD;
        WAIT_MOD: begin
          // Outputs are registered, so the next call's operands are taken from the remainder.
          if (mod_valid_i) begin
            if (mod_ergebnis_i == '0) begin
              ergebnis_o <= b_q;
              busy_o     <= 1'b0;
              valid_o    <= 1'b1;
              state_q    <= DONE;
            end else begin
              a_q         <= b_q;
              b_q         <= mod_ergebnis_i;
              mod_start_o <= 1'b1;
              mod_zahl1_o <= b_q;
              mod_zahl2_o <= mod_ergebnis_i;
              state_q     <= START_MOD;
`ifdef GGT_ITER_COUNT_EN
              iter_o      <= sat_inc(iter_o);
`endif
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
